serial_field_sequencer: RTL and testbench

- Parametrised successor to the team's multi-state serial logic-analyser sequencer.
- Walks a runtime-programmable table of NUM_STATES capture states. Each state shifts in a configurable number of bits from a 1-bit serial probe, in MSB-first or LSB-first order.
- Emits each captured field with its state index, then jumps to the programmed next state. A state marked "last" ends the frame.
- Sits behind the probe synchroniser and feeds the analyser's capture FIFO / display logic.

---
 rtl/serial_field_seq_pkg.sv | 24 ++
 rtl/serial_field_seq_shifter.sv | 46 ++++
 rtl/serial_field_sequencer.sv | 178 +++++++++++++++++
 tb/tb_serial_field_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_field_seq_pkg.sv
// Shared types for the serial field sequencer: FSM states, table entry layout and its reset value.
// Entry widths follow the default sizing; change them here together with the top-level parameters.
package serial_field_seq_pkg;

  localparam int SFS_NUM_STATES  = 8;
  localparam int SFS_MAX_FIELD_W = 32;
  localparam int SFS_STATE_W     = (SFS_NUM_STATES > 1) ? $clog2(SFS_NUM_STATES) : 1;
  localparam int SFS_LEN_W       = $clog2(SFS_MAX_FIELD_W + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [SFS_LEN_W-1:0]   len;
    logic [SFS_STATE_W-1:0] next;
    logic                   lsb_first;
    logic                   last;
  } entry_t;

  localparam entry_t ENTRY_RST = '{len: '0, next: '0, lsb_first: 1'b0, last: 1'b1};

endpackage

// File: rtl/serial_field_seq_shifter.sv
// Bit accumulator for one field: MSB-first shift or LSB-first indexed placement, with a bit counter.
// done/data describe the field as it stands after the current sample, so the caller can latch it on that edge.
module field_shifter #(
  parameter int MAX_FIELD_W = 32,
  parameter int LEN_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   sample,
  input  logic                   sdata,
  input  logic                   lsb_first,
  input  logic [LEN_W-1:0]       len,
  output logic                   done,
  output logic [MAX_FIELD_W-1:0] data
);

  logic [MAX_FIELD_W-1:0] sh_q, sh_d, sh_upd;
  logic [LEN_W-1:0]       cnt_q, cnt_d, cnt_upd;

  always_comb begin
    sh_upd  = sh_q;
    cnt_upd = cnt_q;
    if (sample) begin
      if (lsb_first) sh_upd = sh_q | (MAX_FIELD_W'(sdata) << cnt_q);
      else           sh_upd = {sh_q[MAX_FIELD_W-2:0], sdata};
      cnt_upd = cnt_q + LEN_W'(1);
    end
    done = sample && (cnt_upd == len);
    data = sh_upd;
    // Clear wins over sample so the completing edge also primes the next field.
    sh_d  = clear ? '0 : sh_upd;
    cnt_d = clear ? '0 : cnt_upd;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_field_sequencer.sv
// Table-driven serial capture sequencer: walks programmed states, emitting one field per state.
// Optional SERIAL_FIELD_SEQ_TIMESTAMP_EN adds a free-running cycle counter and the fld_ts output.
module serial_field_sequencer
  import serial_field_seq_pkg::*;
#(
  parameter int NUM_STATES  = SFS_NUM_STATES,
  parameter int MAX_FIELD_W = SFS_MAX_FIELD_W,
  parameter int START_STATE = 0,
  localparam int STATE_W    = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int LEN_W      = $clog2(MAX_FIELD_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [STATE_W-1:0]     cfg_addr,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic [STATE_W-1:0]     cfg_next,
  input  logic                   cfg_lsb_first,
  input  logic                   cfg_last,
  output logic                   cfg_err,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_en,
  input  logic                   sdata,
  output logic                   busy,
  output logic                   fld_valid,
  output logic [MAX_FIELD_W-1:0] fld_data,
  output logic [STATE_W-1:0]     fld_state,
  output logic                   frame_done
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]            fld_ts
`endif
);

  seq_state_e             state_q, state_d;
  logic [STATE_W-1:0]     cur_q, cur_d;
  entry_t                 tbl_q [NUM_STATES];
  entry_t                 tbl_d [NUM_STATES];
  entry_t                 ent;
  logic                   busy_q, busy_d;
  logic                   fld_valid_q, fld_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [MAX_FIELD_W-1:0] fld_data_q, fld_data_d;
  logic [STATE_W-1:0]     fld_state_q, fld_state_d;
  logic                   sh_clear, sh_sample, sh_done;
  logic [MAX_FIELD_W-1:0] sh_data;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
  logic [31:0]            ts_q, ts_d, fld_ts_q, fld_ts_d;
`endif

  assign ent = tbl_q[cur_q];

  field_shifter #(
    .MAX_FIELD_W (MAX_FIELD_W),
    .LEN_W       (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (sh_clear),
    .sample    (sh_sample),
    .sdata     (sdata),
    .lsb_first (ent.lsb_first),
    .len       (ent.len),
    .done      (sh_done),
    .data      (sh_data)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    tbl_d        = tbl_q;
    fld_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    fld_data_d   = fld_data_q;
    fld_state_d  = fld_state_q;
    sh_clear     = 1'b0;
    sh_sample    = 1'b0;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
    ts_d         = ts_q + 32'd1;
    fld_ts_d     = fld_ts_q;
`endif

    // The table is only writable while idle, so a running frame never sees it change.
    if (cfg_we) begin
      if (state_q != IDLE || cfg_len > LEN_W'(MAX_FIELD_W)) begin
        cfg_err_d = 1'b1;
      end else begin
        tbl_d[cfg_addr] = '{len: cfg_len, next: cfg_next, lsb_first: cfg_lsb_first, last: cfg_last};
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = CAPTURE;
          cur_d    = STATE_W'(START_STATE);
          sh_clear = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d  = IDLE;
          sh_clear = 1'b1;
        end else if (ent.len == '0) begin
          sh_clear = 1'b1;
          if (ent.last) state_d = IDLE;
          else          cur_d   = ent.next;
        end else if (sample_en) begin
          sh_sample = 1'b1;
          if (sh_done) begin
            fld_valid_d = 1'b1;
            fld_data_d  = sh_data;
            fld_state_d = cur_q;
            sh_clear    = 1'b1;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
            fld_ts_d    = ts_q;
`endif
            if (ent.last) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              cur_d = ent.next;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      busy_q       <= 1'b0;
      fld_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      fld_data_q   <= '0;
      fld_state_q  <= '0;
      for (int i = 0; i < NUM_STATES; i++) tbl_q[i] <= ENTRY_RST;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
      ts_q         <= '0;
      fld_ts_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      busy_q       <= busy_d;
      fld_valid_q  <= fld_valid_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
      fld_data_q   <= fld_data_d;
      fld_state_q  <= fld_state_d;
      tbl_q        <= tbl_d;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
      ts_q         <= ts_d;
      fld_ts_q     <= fld_ts_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign fld_valid  = fld_valid_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign fld_data   = fld_data_q;
  assign fld_state  = fld_state_q;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
  assign fld_ts     = fld_ts_q;
`endif

endmodule

// File: tb/tb_serial_field_sequencer.sv
// Self-checking bench for serial_field_sequencer: directed scenarios plus randomized frames
// checked against a table-walking reference model.
module tb_serial_field_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [5:0]  cfg_len = '0;
  logic [2:0]  cfg_next = '0;
  logic        cfg_lsb_first = 1'b0;
  logic        cfg_last = 1'b0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sample_en = 1'b0;
  logic        sdata = 1'b0;
  logic        busy;
  logic        fld_valid;
  logic [31:0] fld_data;
  logic [2:0]  fld_state;
  logic        frame_done;
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
  logic [31:0] fld_ts;
`endif

  serial_field_sequencer #(.NUM_STATES(8), .MAX_FIELD_W(32), .START_STATE(0)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .cfg_next(cfg_next), .cfg_lsb_first(cfg_lsb_first), .cfg_last(cfg_last), .cfg_err(cfg_err),
    .start(start), .abort(abort), .sample_en(sample_en), .sdata(sdata), .busy(busy),
    .fld_valid(fld_valid), .fld_data(fld_data), .fld_state(fld_state), .frame_done(frame_done)
`ifdef SERIAL_FIELD_SEQ_TIMESTAMP_EN
    , .fld_ts(fld_ts)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          nsamp = 0;
  logic [63:0] ev[$];
  logic [63:0] xq[$];
  logic [63:0] got;
  bit          stim[$];
  int          m_len[8];
  int          m_next[8];
  bit          m_lsb[8];
  bit          m_last[8];

  function automatic logic [63:0] pk(input logic [31:0] d, input int s, input bit fv, input bit fd, input int n);
    return {6'b0, n[15:0], s[7:0], fv, fd, d};
  endfunction

  task automatic step();
    @(posedge clk);
    if (sample_en) nsamp++;
    #1;
    if (fld_valid || frame_done) ev.push_back(pk(fld_data, int'(fld_state), fld_valid, frame_done, nsamp));
  endtask

  task automatic reset_mirror();
    for (int i = 0; i < 8; i++) begin
      m_len[i] = 0; m_next[i] = 0; m_lsb[i] = 0; m_last[i] = 1;
    end
  endtask

  task automatic write_entry(input int a, input int l, input int n, input bit lsb, input bit last);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_len = 6'(l); cfg_next = 3'(n);
    cfg_lsb_first = lsb; cfg_last = last;
    step();
    cfg_we = 1'b0;
    m_len[a] = l; m_next[a] = n; m_lsb[a] = lsb; m_last[a] = last;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    nsamp = 0;
  endtask

  // mode 0: back-to-back samples, 1: idle cycle between samples, 2: random idle cycles
  task automatic feed(input int mode, input int tail);
    for (int i = 0; i < stim.size(); i++) begin
      sample_en = 1'b1; sdata = stim[i];
      step();
      if ((mode == 1 && i != stim.size() - 1) || (mode == 2 && $urandom_range(0, 99) < 30)) begin
        sample_en = 1'b0;
        step();
      end
    end
    sample_en = 1'b0; sdata = 1'b0;
    repeat (tail) step();
  endtask

  // Walks the programmed table from the start state, consuming bits from stim.
  function automatic void model_run();
    int st;
    int pos;
    logic [31:0] val;
    st = 0; pos = 0;
    xq.delete();
    for (int g = 0; g < 64; g++) begin
      if (m_len[st] != 0) begin
        if (pos + m_len[st] > stim.size()) return;
        val = 0;
        for (int b = 0; b < m_len[st]; b++) begin
          if (m_lsb[st]) val[b] = stim[pos + b];
          else           val = {val[30:0], stim[pos + b]};
        end
        pos += m_len[st];
        xq.push_back(pk(val, st, 1'b1, m_last[st], pos));
      end
      if (m_last[st]) return;
      st = m_next[st];
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0; step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (fld_valid !== 1'b0) $display("FAIL reset_fld_valid got %b want 0", fld_valid); else passes++;
    checks++; if (fld_data !== 32'h0) $display("FAIL reset_fld_data got %h want 0", fld_data); else passes++;
    checks++; if (fld_state !== 3'h0) $display("FAIL reset_fld_state got %h want 0", fld_state); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passes++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else passes++;
    rst = 1'b1; reset_mirror(); step();
  endtask

  task automatic test_msb_two_state();
    write_entry(0, 4, 1, 0, 0);
    write_entry(1, 8, 0, 0, 1);
    ev.delete(); start_frame();
    stim = {1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    feed(0, 2);
    xq = {pk(32'hB, 0, 1, 0, 4), pk(32'hA5, 1, 1, 1, 12)};
    checks++; if (ev.size() != xq.size()) $display("FAIL msb_count got %0d want %0d", ev.size(), xq.size()); else passes++;
    foreach (xq[k]) begin
      checks++; got = (k < ev.size()) ? ev[k] : '1;
      if (got !== xq[k]) $display("FAIL msb_ev%0d got %h want %h", k, got, xq[k]); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL msb_busy_end got %b want 0", busy); else passes++;
  endtask

  task automatic test_lsb_first();
    write_entry(0, 8, 0, 1, 1);
    ev.delete(); start_frame();
    stim = {1, 0, 1, 0, 0, 1, 0, 1};
    feed(0, 2);
    checks++; if (ev.size() != 1) $display("FAIL lsb_count got %0d want 1", ev.size()); else passes++;
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (got !== pk(32'hA5, 0, 1, 1, 8)) $display("FAIL lsb_ev got %h want %h", got, pk(32'hA5, 0, 1, 1, 8)); else passes++;
  endtask

  task automatic test_gapped();
    write_entry(0, 4, 0, 0, 1);
    ev.delete(); start_frame();
    stim = {1, 1, 0, 1};
    feed(1, 2);
    checks++; if (ev.size() != 1) $display("FAIL gap_count got %0d want 1", ev.size()); else passes++;
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (got !== pk(32'hD, 0, 1, 1, 4)) $display("FAIL gap_ev got %h want %h", got, pk(32'hD, 0, 1, 1, 4)); else passes++;
  endtask

  task automatic test_abort();
    write_entry(0, 8, 0, 0, 1);
    ev.delete(); start_frame();
    stim = {1, 1};
    feed(0, 0);
    abort = 1'b1; sample_en = 1'b1; sdata = 1'b1;
    step();
    abort = 1'b0; sample_en = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
    repeat (3) step();
    checks++; if (ev.size() != 0) $display("FAIL abort_pulses got %0d want 0", ev.size()); else passes++;
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL start_abort_busy got %b want 0", busy); else passes++;
    ev.delete(); start_frame();
    stim = {0, 0, 1, 1, 1, 1, 0, 0};
    feed(0, 2);
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (ev.size() != 1 || got !== pk(32'h3C, 0, 1, 1, 8)) $display("FAIL abort_restart got %h want %h", got, pk(32'h3C, 0, 1, 1, 8)); else passes++;
  endtask

  task automatic test_len0_loop();
    write_entry(0, 0, 1, 0, 0);
    write_entry(1, 2, 1, 0, 0);
    ev.delete(); start_frame();
    step();
    checks++; if (busy !== 1'b1) $display("FAIL len0_busy_skip got %b want 1", busy); else passes++;
    nsamp = 0;
    stim = {1, 0, 0, 1, 1, 1};
    feed(0, 0);
    xq = {pk(32'h2, 1, 1, 0, 2), pk(32'h1, 1, 1, 0, 4), pk(32'h3, 1, 1, 0, 6)};
    checks++; if (ev.size() != xq.size()) $display("FAIL len0_count got %0d want %0d", ev.size(), xq.size()); else passes++;
    foreach (xq[k]) begin
      checks++; got = (k < ev.size()) ? ev[k] : '1;
      if (got !== xq[k]) $display("FAIL len0_ev%0d got %h want %h", k, got, xq[k]); else passes++;
    end
    checks++; if (busy !== 1'b1) $display("FAIL len0_busy_loop got %b want 1", busy); else passes++;
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL len0_abort got %b want 0", busy); else passes++;
  endtask

  task automatic test_cfg_reject();
    write_entry(0, 4, 0, 0, 1);
    ev.delete(); start_frame();
    stim = {1};
    feed(0, 0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_len = 6'd8; cfg_next = 3'd2; cfg_lsb_first = 1'b1; cfg_last = 1'b0;
    step();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) $display("FAIL busy_write_err got %b want 1", cfg_err); else passes++;
    step();
    checks++; if (cfg_err !== 1'b0) $display("FAIL busy_write_err_pulse got %b want 0", cfg_err); else passes++;
    stim = {0, 1, 1};
    feed(0, 2);
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (ev.size() != 1 || got !== pk(32'hB, 0, 1, 1, 4)) $display("FAIL busy_write_table got %h want %h", got, pk(32'hB, 0, 1, 1, 4)); else passes++;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_len = 6'd33; cfg_next = 3'd0; cfg_lsb_first = 1'b1; cfg_last = 1'b1;
    step();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) $display("FAIL len_over_err got %b want 1", cfg_err); else passes++;
    ev.delete(); start_frame();
    stim = {0, 1, 1, 0};
    feed(0, 2);
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (ev.size() != 1 || got !== pk(32'h6, 0, 1, 1, 4)) $display("FAIL len_over_table got %h want %h", got, pk(32'h6, 0, 1, 1, 4)); else passes++;
  endtask

  task automatic test_start_with_write();
    ev.delete();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_len = 6'd3; cfg_next = 3'd0; cfg_lsb_first = 1'b1; cfg_last = 1'b1;
    start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0; nsamp = 0;
    m_len[0] = 3; m_next[0] = 0; m_lsb[0] = 1; m_last[0] = 1;
    checks++; if (cfg_err !== 1'b0) $display("FAIL idle_write_err got %b want 0", cfg_err); else passes++;
    stim = {1, 1, 0};
    feed(0, 2);
    checks++; got = (ev.size() > 0) ? ev[0] : '1;
    if (ev.size() != 1 || got !== pk(32'h3, 0, 1, 1, 3)) $display("FAIL start_write_ev got %h want %h", got, pk(32'h3, 0, 1, 1, 3)); else passes++;
  endtask

  task automatic test_random();
    int l_r[8];
    int n_r[8];
    bit b_r[8];
    bit t_r[8];
    int path[4];
    int k;
    int off;
    int total;
    for (int f = 0; f < 8; f++) begin
      for (int a = 0; a < 8; a++) begin
        l_r[a] = $urandom_range(1, 32); n_r[a] = $urandom_range(0, 7);
        b_r[a] = 1'($urandom_range(0, 1)); t_r[a] = 1'($urandom_range(0, 1));
      end
      k = $urandom_range(1, 4); off = $urandom_range(0, 6);
      path[0] = 0;
      for (int j = 1; j < 4; j++) path[j] = 1 + ((off + j) % 7);
      for (int j = 0; j < k; j++) begin
        t_r[path[j]] = (j == k - 1);
        if (j < k - 1) n_r[path[j]] = path[j + 1];
      end
      for (int a = 0; a < 8; a++) write_entry(a, l_r[a], n_r[a], b_r[a], t_r[a]);
      total = 0;
      for (int j = 0; j < k; j++) total += l_r[path[j]];
      stim.delete();
      for (int i = 0; i < total; i++) stim.push_back(1'($urandom_range(0, 1)));
      model_run();
      ev.delete(); start_frame();
      feed(2, 2);
      checks++; if (ev.size() != xq.size()) $display("FAIL rand%0d_count got %0d want %0d", f, ev.size(), xq.size()); else passes++;
      foreach (xq[q]) begin
        checks++; got = (q < ev.size()) ? ev[q] : '1;
        if (got !== xq[q]) $display("FAIL rand%0d_ev%0d got %h want %h", f, q, got, xq[q]); else passes++;
      end
      checks++; if (busy !== 1'b0) $display("FAIL rand%0d_busy got %b want 0", f, busy); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    write_entry(0, 8, 0, 0, 1);
    ev.delete(); start_frame();
    stim = {1, 0, 1};
    feed(0, 0);
    rst = 1'b0; step();
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passes++;
    checks++; if (fld_data !== 32'h0) $display("FAIL rstmid_fld_data got %h want 0", fld_data); else passes++;
    checks++; if (fld_valid !== 1'b0 || frame_done !== 1'b0) $display("FAIL rstmid_pulses got %b%b want 00", fld_valid, frame_done); else passes++;
    rst = 1'b1; reset_mirror();
    ev.delete(); start_frame();
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_start_busy got %b want 1", busy); else passes++;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_end_busy got %b want 0", busy); else passes++;
    repeat (3) step();
    checks++; if (ev.size() != 0) $display("FAIL rstmid_no_field got %0d want 0", ev.size()); else passes++;
  endtask

  initial begin
    reset_mirror();
    test_reset();
    test_msb_two_state();
    test_lsb_first();
    test_gapped();
    test_abort();
    test_len0_loop();
    test_cfg_reject();
    test_start_with_write();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
